// File: rtl/rx_anc_phase_seq_pkg.sv
// Shared types and defaults for the RX ANC multi-tone phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_anc_pkg;

    localparam int DEF_PHASE_WIDTH = 24;
    localparam int DEF_COUNT_WIDTH = 24;
    localparam int DEF_NUM_TONES   = 4;
    localparam int DEF_INC_VAL     = 2048;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width of a tone index. Never less than one bit, so a single-tone table still has an address.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_anc_phase_seq_if.sv
// Phase-word output stream plus per-word status of the phase sequencer.
// Latency: n/a (wires only).
// Backpressure: m_phase_tready from the consumer stalls the producer.
interface rx_anc_phase_seq_if
    import rx_anc_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int IDX_W       = 2
);
    logic [PHASE_WIDTH-1:0] m_phase_tdata;
    logic                   m_phase_tvalid;
    logic                   m_phase_tlast;
    logic                   m_phase_tready;
    logic                   seq_last;
    logic [IDX_W-1:0]       tone_idx;
    logic [COUNT_WIDTH-1:0] sample_cnt;
    logic                   busy;

    modport master (
        output m_phase_tdata, m_phase_tvalid, m_phase_tlast, seq_last,
               tone_idx, sample_cnt, busy,
        input  m_phase_tready
    );

    modport slave (
        input  m_phase_tdata, m_phase_tvalid, m_phase_tlast, seq_last,
               tone_idx, sample_cnt, busy,
        output m_phase_tready
    );
endinterface

// File: rtl/rx_anc_phase_seq_tone_table.sv
// Phase-increment table: NUM_TONES registers, one write port, one combinational read port.
// Latency: a write at edge k is readable right after edge k.
// Backpressure: none; writes are always accepted, out-of-range addresses are dropped.
module rx_anc_tone_table
    import rx_anc_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int NUM_TONES   = DEF_NUM_TONES,
    parameter int IDX_W       = 2,
    parameter int DEF_INC     = DEF_INC_VAL
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [PHASE_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [PHASE_WIDTH-1:0] rd_data
);

    logic [PHASE_WIDTH-1:0] tbl_q [NUM_TONES];
    logic [PHASE_WIDTH-1:0] tbl_d [NUM_TONES];

    // Address decode: an address with no matching entry simply writes nothing.
    always_comb begin
        tbl_d = tbl_q;
        for (int i = 0; i < NUM_TONES; i++) begin
            if (wr_en && (wr_addr == IDX_W'(i))) begin
                tbl_d[i] = wr_data;
            end
        end
    end

    // Table storage; only the hard reset restores the defaults.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TONES; i++) begin
                tbl_q[i] <= PHASE_WIDTH'(DEF_INC);
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Read mux written as a compare loop so non-power-of-two depths never index past the array.
    always_comb begin
        rd_data = PHASE_WIDTH'(DEF_INC);
        for (int i = 0; i < NUM_TONES; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_data = tbl_q[i];
            end
        end
    end

endmodule

// File: rtl/rx_anc_phase_seq.sv
// Multi-tone phase sequencer: per-sample phase words, each tone dwelling cfg_nsig samples.
// Latency: first word valid one cycle after enable is sampled in IDLE; 1 word/cycle after that.
// Backpressure: every output holds while tvalid & !tready; state advances only on accepted beats.
module rx_anc_phase_seq
    import rx_anc_pkg::*;
#(
    parameter int                     PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int                     COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int                     NUM_TONES   = DEF_NUM_TONES,
    parameter logic [PHASE_WIDTH-1:0] START_PH    = '0,
    parameter int                     DEF_INC     = DEF_INC_VAL,
    localparam int                    IDX_W       = idx_w(NUM_TONES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   srst,
    input  logic                   enable,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_addr,
    input  logic [PHASE_WIDTH-1:0] cfg_inc,
    input  logic [COUNT_WIDTH-1:0] cfg_nsig,
    input  logic [IDX_W:0]         cfg_ntones,
    rx_anc_phase_seq_if.master     phase_if
);

    localparam logic [IDX_W:0] NT_MAX = (IDX_W+1)'(NUM_TONES);

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] inc_q, inc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] nsig_q, nsig_d;
    logic [IDX_W-1:0]       tone_q, tone_d;
    logic [IDX_W:0]         ntones_q, ntones_d;
    logic                   tlast_q, tlast_d;
    logic                   seq_last_q, seq_last_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic                   cfg_ok;
    logic                   last_tone;
    logic                   load_cfg;
    logic [IDX_W:0]         ntones_clamp;
    logic [IDX_W-1:0]       tone_ld;
    logic [COUNT_WIDTH-1:0] nsig_ld;
    logic [IDX_W:0]         ntones_ld;
    logic                   ld_tlast;
    logic                   ld_seq;
    logic [PHASE_WIDTH-1:0] tbl_rd;

    // A beat moves only when a registered word is on the bus and the consumer takes it.
    assign accept       = valid_q & phase_if.m_phase_tready;
    assign cfg_ok       = (cfg_ntones != '0) && (cfg_nsig != '0);
    assign ntones_clamp = (cfg_ntones > NT_MAX) ? NT_MAX : cfg_ntones;
    assign last_tone    = ({1'b0, tone_q} == (ntones_q - (IDX_W+1)'(1)));

    // Configuration is re-sampled at sequence start and at each wrap back to tone 0.
    assign load_cfg  = (state_q == ST_IDLE) || (tlast_q && last_tone);
    assign tone_ld   = ((state_q == ST_IDLE) || last_tone) ? '0 : (tone_q + IDX_W'(1));
    assign nsig_ld   = load_cfg ? cfg_nsig     : nsig_q;
    assign ntones_ld = load_cfg ? ntones_clamp : ntones_q;
    assign ld_tlast  = (nsig_ld == COUNT_WIDTH'(1));
    assign ld_seq    = ld_tlast && ({1'b0, tone_ld} == (ntones_ld - (IDX_W+1)'(1)));

    rx_anc_tone_table #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .NUM_TONES   (NUM_TONES),
        .IDX_W       (IDX_W),
        .DEF_INC     (DEF_INC)
    ) u_tbl (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_inc),
        .rd_addr (tone_ld),
        .rd_data (tbl_rd)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on a usable config, drain to the dwell end when enable drops.
    always_comb begin
        state_d = state_q;
        if (srst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && cfg_ok) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (accept && tlast_q && !enable) begin
                        state_d = ST_IDLE;
                    end else if (accept && tlast_q && last_tone && !cfg_ok) begin
                        state_d = ST_IDLE;
                    end else if (!enable) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: load a dwell, step the accumulator, or clear outputs when falling back to IDLE.
    always_comb begin
        phase_d    = phase_q;
        inc_d      = inc_q;
        count_d    = count_q;
        nsig_d     = nsig_q;
        tone_d     = tone_q;
        ntones_d   = ntones_q;
        tlast_d    = tlast_q;
        seq_last_d = seq_last_q;
        valid_d    = (state_d != ST_IDLE);
        if (srst || ((state_q != ST_IDLE) && (state_d == ST_IDLE))) begin
            phase_d    = START_PH;
            count_d    = '0;
            tone_d     = '0;
            tlast_d    = 1'b0;
            seq_last_d = 1'b0;
        end else if (((state_q == ST_IDLE) && (state_d == ST_RUN)) || (accept && tlast_q)) begin
            phase_d    = START_PH;
            count_d    = COUNT_WIDTH'(1);
            tone_d     = tone_ld;
            inc_d      = tbl_rd;
            nsig_d     = nsig_ld;
            ntones_d   = ntones_ld;
            tlast_d    = ld_tlast;
            seq_last_d = ld_seq;
        end else if (accept) begin
            phase_d    = phase_q + inc_q;
            count_d    = count_q + COUNT_WIDTH'(1);
            tlast_d    = ((count_q + COUNT_WIDTH'(1)) == nsig_q);
            seq_last_d = ((count_q + COUNT_WIDTH'(1)) == nsig_q) && last_tone;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= START_PH;
            inc_q      <= PHASE_WIDTH'(DEF_INC);
            count_q    <= '0;
            nsig_q     <= '0;
            tone_q     <= '0;
            ntones_q   <= '0;
            tlast_q    <= 1'b0;
            seq_last_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            inc_q      <= inc_d;
            count_q    <= count_d;
            nsig_q     <= nsig_d;
            tone_q     <= tone_d;
            ntones_q   <= ntones_d;
            tlast_q    <= tlast_d;
            seq_last_q <= seq_last_d;
            valid_q    <= valid_d;
        end
    end

    assign phase_if.m_phase_tdata  = phase_q;
    assign phase_if.m_phase_tvalid = valid_q;
    assign phase_if.m_phase_tlast  = tlast_q;
    assign phase_if.seq_last       = seq_last_q;
    assign phase_if.tone_idx       = tone_q;
    assign phase_if.sample_cnt     = count_q;
    assign phase_if.busy           = valid_q;

endmodule

// File: tb/tb_rx_anc_phase_seq.sv
// Self-checking bench for rx_anc_phase_seq against a sample-level reference model.
// Latency: n/a.
// Backpressure: tready is driven either constantly high or randomly.
module tb_rx_anc_phase_seq;
    import rx_anc_pkg::*;

    localparam int PW = 24;
    localparam int CW = 24;
    localparam int NT = 4;
    localparam int IW = 2;
    localparam logic [PW-1:0] START = 24'h000000;
    localparam logic [PW-1:0] DEFI  = 24'd2048;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          srst = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_inc = '0;
    logic [CW-1:0] cfg_nsig = '0;
    logic [IW:0]   cfg_ntones = '0;

    rx_anc_phase_seq_if #(.PHASE_WIDTH(PW), .COUNT_WIDTH(CW), .IDX_W(IW)) bus ();

    rx_anc_phase_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .srst       (srst),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_inc    (cfg_inc),
        .cfg_nsig   (cfg_nsig),
        .cfg_ntones (cfg_ntones),
        .phase_if   (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    bit cap_en  = 0;
    bit rnd_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // tready driver: always high, or a coin flip per cycle.
    initial begin
        bus.m_phase_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_phase_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- reference model (sample-level) ----------------
    bit          m_act;
    int          m_k;
    int          m_tone;
    int          m_nsig;
    int          m_nt;
    logic [PW-1:0] m_inc;
    logic [PW-1:0] m_tbl [NT];
    logic [PW-1:0] m_old [NT];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 0; m_k = 0; m_tone = 0; m_nsig = 0; m_nt = 0; m_inc = DEFI;
            for (int i = 0; i < NT; i++) m_tbl[i] = DEFI;
        end else begin
            m_old = m_tbl;
            if (cfg_we && (int'(cfg_addr) < NT)) m_tbl[cfg_addr] = cfg_inc;
            if (srst) begin
                m_act = 0; m_k = 0; m_tone = 0;
            end else if (!m_act) begin
                if (enable && cfg_ntones != 0 && cfg_nsig != 0) begin
                    m_act = 1; m_nsig = int'(cfg_nsig);
                    m_nt = (int'(cfg_ntones) > NT) ? NT : int'(cfg_ntones);
                    m_tone = 0; m_k = 1; m_inc = m_old[0];
                end
            end else if (bus.m_phase_tready) begin
                if (m_k != m_nsig) begin
                    m_k++;
                end else if (!enable) begin
                    m_act = 0; m_k = 0; m_tone = 0;
                end else if (m_tone == m_nt - 1) begin
                    if (cfg_ntones == 0 || cfg_nsig == 0) begin
                        m_act = 0; m_k = 0; m_tone = 0;
                    end else begin
                        m_nsig = int'(cfg_nsig);
                        m_nt = (int'(cfg_ntones) > NT) ? NT : int'(cfg_ntones);
                        m_tone = 0; m_k = 1; m_inc = m_old[0];
                    end
                end else begin
                    m_tone++; m_k = 1; m_inc = m_old[m_tone];
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [47:0] prod;
            logic [PW-1:0] e_dat;
            bit e_last;
            prod   = 48'(m_act ? (m_k - 1) : 0) * 48'(m_inc);
            e_dat  = m_act ? PW'(48'(START) + prod) : START;
            e_last = m_act && (m_k == m_nsig);
            check("tvalid", 32'(bus.m_phase_tvalid), 32'(m_act));
            check("busy", 32'(bus.busy), 32'(m_act));
            check("tdata", 32'(bus.m_phase_tdata), 32'(e_dat));
            check("tlast", 32'(bus.m_phase_tlast), 32'(e_last));
            check("seq_last", 32'(bus.seq_last), 32'(e_last && (m_tone == m_nt - 1)));
            check("tone_idx", 32'(bus.tone_idx), 32'(m_act ? m_tone : 0));
            check("sample_cnt", 32'(bus.sample_cnt), 32'(m_act ? m_k : 0));
        end
    end

    // ---------------- accepted-beat capture ----------------
    logic [PW-1:0] wq [$];
    bit            lq [$];
    bit            sq [$];

    always @(negedge clk) begin
        if (cap_en && bus.m_phase_tvalid && bus.m_phase_tready) begin
            wq.push_back(bus.m_phase_tdata);
            lq.push_back(bus.m_phase_tlast);
            sq.push_back(bus.seq_last);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int addr, input logic [PW-1:0] val);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_inc = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic clear_cap();
        wq.delete(); lq.delete(); sq.delete();
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int c = 0;
        while (wq.size() < n && c < budget) begin @(negedge clk); c++; end
        check(name, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (bus.busy && c < 200) begin @(negedge clk); c++; end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_word(input int tone, input int cnt, input string name);
        int c = 0;
        @(negedge clk);
        while (!(bus.m_phase_tvalid && (cnt < 0 || int'(bus.sample_cnt) == cnt) &&
                 (tone < 0 || int'(bus.tone_idx) == tone)) && c < 200) begin
            @(negedge clk); c++;
        end
        check(name, 32'(c < 200), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [PW-1:0] two_tone [8] = '{24'h0, 24'h800, 24'h1000, 24'h1800,
                                     24'h0, 24'h1000, 24'h2000, 24'h3000};

    initial begin
        int beats, loops;
        bit last_tl;

        // Reset state.
        tick(3);
        chk_en = 1;
        @(negedge clk);
        check("rst_tvalid", 32'(bus.m_phase_tvalid), 0);
        check("rst_tdata", 32'(bus.m_phase_tdata), 32'(START));
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cnt", 32'(bus.sample_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);

        // Two-tone sequence at full throughput, then with random stalls.
        tbl_write(0, 24'h000800);
        tbl_write(1, 24'h001000);
        cfg_nsig = 4; cfg_ntones = 2;
        for (int pass = 0; pass < 2; pass++) begin
            rnd_rdy = (pass == 1);
            clear_cap();
            cap_en = 1; enable = 1;
            wait_words(16, 400, "two_tone_words");
            tick(1);
            enable = 0;
            wait_idle("two_tone_idle");
            cap_en = 0;
            for (int i = 0; i < 16 && i < wq.size(); i++) begin
                check(pass ? "bp_word" : "tt_word", 32'(wq[i]), 32'(two_tone[i % 8]));
                check(pass ? "bp_tlast" : "tt_tlast", 32'(lq[i]), 32'((i % 4) == 3));
                check(pass ? "bp_seq" : "tt_seq", 32'(sq[i]), 32'((i % 8) == 7));
            end
        end
        rnd_rdy = 0;
        tick(2);

        // Phase wrap.
        tbl_write(0, 24'hC00000);
        cfg_nsig = 3; cfg_ntones = 1;
        clear_cap(); cap_en = 1; enable = 1;
        wait_words(4, 50, "wrap_words");
        tick(1); enable = 0;
        wait_idle("wrap_idle");
        cap_en = 0;
        if (wq.size() >= 4) begin
            check("wrap_w0", 32'(wq[0]), 32'h0);
            check("wrap_w1", 32'(wq[1]), 32'hC00000);
            check("wrap_w2", 32'(wq[2]), 32'h800000);
            check("wrap_w3", 32'(wq[3]), 32'h0);
        end

        // Enable drop at sample 2: two more words, the last with tlast, then busy falls.
        tbl_write(0, 24'h000800);
        cfg_nsig = 4; cfg_ntones = 2;
        enable = 1;
        wait_word(0, 2, "drop_find");
        enable = 0;
        beats = 0; loops = 0; last_tl = 0;
        while (loops < 20) begin
            @(negedge clk); loops++;
            if (!bus.busy) break;
            if (bus.m_phase_tvalid && bus.m_phase_tready) begin
                beats++; last_tl = bus.m_phase_tlast;
            end
        end
        check("drop_beats", 32'(beats), 2);
        check("drop_last_tlast", 32'(last_tl), 1);
        check("drop_busy_cycle", 32'(loops), 3);
        tick(2);

        // Table write mid-dwell of tone 1 only affects the next tone-1 dwell.
        enable = 1;
        wait_word(1, 2, "upd_find");
        tbl_write(1, 24'h003000);
        wait_word(1, 4, "upd_find_a");
        check("upd_old_dwell", 32'(bus.m_phase_tdata), 32'h3000);
        wait_word(1, 4, "upd_find_b");
        check("upd_new_dwell", 32'(bus.m_phase_tdata), 32'h9000);

        // srst mid-dwell, restart uses the table as written before srst.
        tbl_write(0, 24'h000123);
        wait_word(-1, 2, "srst_find");
        srst = 1;
        @(negedge clk);
        check("srst_tvalid", 32'(bus.m_phase_tvalid), 0);
        srst = 0;
        wait_word(-1, -1, "srst_restart");
        check("srst_r_tdata", 32'(bus.m_phase_tdata), 32'(START));
        check("srst_r_tone", 32'(bus.tone_idx), 0);
        check("srst_r_cnt", 32'(bus.sample_cnt), 1);
        @(negedge clk);
        check("srst_r_inc", 32'(bus.m_phase_tdata), 32'h123);
        enable = 0;
        wait_idle("srst_idle");

        // Hard reset restores the table defaults.
        @(negedge clk); reset_n = 0;
        @(negedge clk); @(negedge clk); reset_n = 1;
        tick(1);
        clear_cap(); cap_en = 1; enable = 1;
        wait_words(8, 50, "rstn_words");
        tick(1); enable = 0;
        wait_idle("rstn_idle");
        cap_en = 0;
        if (wq.size() >= 8) begin
            check("rstn_tone0_inc", 32'(wq[1]), 32'(DEFI));
            check("rstn_tone1_inc", 32'(wq[5]), 32'(DEFI));
            check("rstn_tone1_w2", 32'(wq[6]), 32'h1000);
        end

        // Degenerate configurations stay idle.
        cfg_ntones = 0; cfg_nsig = 4; enable = 1;
        tick(8);
        @(negedge clk);
        check("nt0_idle", 32'(bus.m_phase_tvalid), 0);
        cfg_ntones = 2; cfg_nsig = 0;
        tick(8);
        @(negedge clk);
        check("ns0_idle", 32'(bus.m_phase_tvalid), 0);
        enable = 0; tick(1);

        // ntones=7 clamps to 4 tones; nsig=1 puts tlast on every word.
        cfg_ntones = 7; cfg_nsig = 1; enable = 1;
        begin
            int c = 0;
            @(negedge clk);
            while (!(bus.m_phase_tvalid && bus.seq_last) && c < 50) begin @(negedge clk); c++; end
            check("clamp_found", 32'(c < 50), 1);
            check("clamp_tone", 32'(bus.tone_idx), 3);
            check("clamp_tdata", 32'(bus.m_phase_tdata), 32'(START));
            check("clamp_tlast", 32'(bus.m_phase_tlast), 1);
        end
        tick(1); enable = 0;
        wait_idle("clamp_idle");

        // Random soak against the model.
        rnd_rdy = 1;
        cfg_ntones = 2; cfg_nsig = 3;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = IW'($urandom_range(0, NT - 1));
            cfg_inc  = PW'($urandom);
            if ($urandom_range(0, 9) == 0) cfg_nsig = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) cfg_ntones = (IW+1)'($urandom_range(0, 7));
            srst = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        cfg_we = 0; srst = 0; enable = 0; rnd_rdy = 0;
        tick(40);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
